// File: rtl/key_entry_if.sv
// Keypad entry bus: raw key code toward the entry block, entry/commit status back.
interface key_entry_if;
   logic [3:0]  key;
   logic [15:0] entry_buf;
   logic [2:0]  digit_cnt;
   logic        busy;
   logic [15:0] value;
   logic        value_valid;
   logic        err;
   logic        timeout;

   modport master (
      output key,
      input  entry_buf, digit_cnt, busy, value, value_valid, err, timeout
   );

   modport slave (
      input  key,
      output entry_buf, digit_cnt, busy, value, value_valid, err, timeout
   );
endinterface

// File: rtl/key_entry.sv
// BCD keypad entry buffer with backspace/clear/enter and registered status pulses.
// Optional idle-abort in ENTRY is built only when KEY_ENTRY_TIMEOUT_EN is defined.
module key_entry #(
   parameter int MAX_DIGITS  = 4,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic         clk,
   input  logic         rst_n,
   key_entry_if.slave   bus
);

   typedef enum logic {S_IDLE, S_ENTRY} state_t;

   localparam logic [15:0] BUF_MASK = (16'h1 << (4 * MAX_DIGITS)) - 16'h1;
   localparam logic [2:0]  MAX_CNT  = 3'(MAX_DIGITS);

   if (MAX_DIGITS < 1 || MAX_DIGITS > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("key_entry: MAX_DIGITS must be 1..4 and TIMEOUT_CYC >= 2");
   end

   state_t      state_q, state_d;
   logic [15:0] buf_q, buf_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] value_q, value_d;
   logic        vv_q, vv_d;
   logic        err_q, err_d;
   logic [3:0]  key_prev_q;
   logic        armed_q;
   logic        evt;

   // key_prev resets to 'no key', so armed_q masks the first cycle after reset
   // to keep a key held through reset release from being seen as a new press.
   assign evt = armed_q && (bus.key != 4'hF) && (bus.key != key_prev_q);

`ifdef KEY_ENTRY_TIMEOUT_EN
   localparam int            CW   = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] idle_q, idle_d;
   logic          to_q, to_d;
   logic          expire;

   assign expire = (state_q == S_ENTRY) && (idle_q == LAST) && !evt;

   always_comb begin
      idle_d = idle_q + 1'b1;
      to_d   = expire;
      if (state_q != S_ENTRY || evt || expire) idle_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
         to_q   <= 1'b0;
      end else begin
         idle_q <= idle_d;
         to_q   <= to_d;
      end
   end

   assign bus.timeout = to_q;
`else
   assign bus.timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      vv_d    = 1'b0;
      err_d   = 1'b0;
      if (evt) begin
         unique case (bus.key)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
               if (state_q == S_IDLE) begin
                  buf_d   = {12'h000, bus.key} & BUF_MASK;
                  cnt_d   = 3'd1;
                  state_d = S_ENTRY;
               end else if (cnt_q < MAX_CNT) begin
                  buf_d = ((buf_q << 4) | {12'h000, bus.key}) & BUF_MASK;
                  cnt_d = cnt_q + 3'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
            4'hA: begin
               if (state_q == S_IDLE) begin
                  err_d = 1'b1;
               end else begin
                  buf_d = buf_q >> 4;
                  cnt_d = cnt_q - 3'd1;
                  if (cnt_q == 3'd1) state_d = S_IDLE;
               end
            end
            4'hB: begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
            4'hC: begin
               if (state_q == S_IDLE) begin
                  err_d = 1'b1;
               end else begin
                  value_d = buf_q;
                  vv_d    = 1'b1;
                  buf_d   = '0;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
            default: ;
         endcase
      end
`ifdef KEY_ENTRY_TIMEOUT_EN
      else if (expire) begin
         buf_d   = '0;
         cnt_d   = '0;
         state_d = S_IDLE;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         buf_q      <= '0;
         cnt_q      <= '0;
         value_q    <= '0;
         vv_q       <= 1'b0;
         err_q      <= 1'b0;
         key_prev_q <= 4'hF;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         value_q    <= value_d;
         vv_q       <= vv_d;
         err_q      <= err_d;
         key_prev_q <= bus.key;
         armed_q    <= 1'b1;
      end
   end

   assign bus.entry_buf   = buf_q;
   assign bus.digit_cnt   = cnt_q;
   assign bus.busy        = (state_q == S_ENTRY);
   assign bus.value       = value_q;
   assign bus.value_valid = vv_q;
   assign bus.err         = err_q;

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL provide parameter MAX_DIGITS, default 4, meaning the maximum BCD digits held (legal range 1..4).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 5000, meaning the idle-abort time in clk cycles (5 s at 1 kHz).
REQ-003 SHALL have port clk  in  1  system clock, 1 kHz, same clock as the keypad scanner.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key  in  4  debounced key code from the scanner; 4'b1111 = no key; held while pressed.
REQ-006 SHALL have port entry_buf  out  16  live BCD digits being typed, least significant digit in [3:0], for display.
REQ-007 SHALL have port digit_cnt  out  3  number of digits currently in entry_buf (0..MAX_DIGITS).
REQ-008 SHALL have port busy  out  1  high while in state ENTRY.
REQ-009 SHALL have port value  out  16  last committed BCD value; holds until the next commit.
REQ-010 SHALL have port value_valid  out  1  one-cycle pulse on commit.
REQ-011 SHALL have port err  out  1  one-cycle pulse on an illegal key.
REQ-012 SHALL have port timeout  out  1  one-cycle pulse on an idle abort.

Function
REQ-013 SHALL register key into key_prev every cycle; an event occurs when key != 4'hF and key != key_prev (one event per press, and a direct change to a new code also counts).
REQ-014 SHALL classify codes: 0x0-0x9 digit, 0xA backspace, 0xB clear, 0xC enter, 0xD/0xE ignored (no effect, no err).
REQ-015 SHALL implement states IDLE (digit_cnt=0) and ENTRY (digit_cnt>=1); all outputs are registered, so the response is visible the cycle after the event edge.
REQ-016 Digit in IDLE: entry_buf={12'h0,d}, digit_cnt=1, go to ENTRY.
REQ-017 Digit in ENTRY with digit_cnt<MAX_DIGITS: entry_buf=(entry_buf<<4)|d truncated to 4*MAX_DIGITS bits, digit_cnt+1.
REQ-018 Digit in ENTRY with digit_cnt==MAX_DIGITS: buffer unchanged, err pulse.
REQ-019 Backspace in ENTRY: entry_buf>>4, digit_cnt-1; reaching 0 goes to IDLE. Backspace in IDLE: err pulse.
REQ-020 Clear in either state: entry_buf=0, digit_cnt=0, go to IDLE, no err.
REQ-021 Enter in ENTRY: value=entry_buf, value_valid pulse, entry_buf=0, digit_cnt=0, go to IDLE. Enter in IDLE: err pulse, value unchanged.
REQ-022 value_valid, err and timeout SHALL be mutually exclusive, each at most one cycle wide.
REQ-023 Unused upper entry_buf/value bits (MAX_DIGITS<4) SHALL read 0.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, entry_buf=0, digit_cnt=0, busy=0, value=0, value_valid=0, err=0, timeout=0, key_prev=4'hF, idle counter=0.
REQ-025 Reset mid-entry SHALL discard partial digits with no pulse; a key still held at release SHALL produce no event until it changes.

Configuration
REQ-026 With KEY_ENTRY_TIMEOUT_EN defined: an idle counter clears on every event and in IDLE; in ENTRY, reaching TIMEOUT_CYC-1 with no event clears entry_buf/digit_cnt, returns to IDLE and pulses timeout; an event in the expiry cycle SHALL win and the timeout SHALL NOT fire.
REQ-027 Without KEY_ENTRY_TIMEOUT_EN: no idle counter is built, the timeout port is tied 0, and ENTRY persists indefinitely.

Verification
REQ-028 Keys 1,2,3,C (each held 5 cycles, 1111 between) -> value=16'h0123, one value_valid pulse, digit_cnt=0, busy=0.
REQ-029 Keys 9,8,7,6,5 -> entry_buf=16'h9876, err pulse on the 5th key; then A -> entry_buf=16'h0987, digit_cnt=3.
REQ-030 C in IDLE -> err pulse, value unchanged; A in IDLE -> err pulse; D/E -> no output change.
REQ-031 Key 4 held 100 cycles -> exactly one event; key 4 changing directly to 5 -> second event, entry_buf=16'h0045.
REQ-032 With the macro: key 7 then 5000 idle cycles -> timeout pulse, entry_buf=0; key 8 on the expiry cycle -> no timeout, entry_buf=16'h0078.
REQ-033 rst_n low after keys 1,2 -> all outputs 0 asynchronously; key held through rst_n release -> no event.
